div_seq: RTL

Parametrised multi-cycle restoring divider that produces quotient and remainder at one bit per clock behind a valid/ready handshake. Unsigned division is always available; signed division can be compiled in. It is the successor to the single-pass combinational divider and is instantiated as the ALU's long-latency divide unit. It holds one operation at a time and applies back-pressure while that operation is busy.

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_seq_step.sv | 24 ++
 rtl/div_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// divide-by-zero quotient fill and the iteration-counter width helper.
package div_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Replicated across the full result width to form the all-ones quotient.
   localparam logic DIVZ_Q_FILL = 1'b1;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_seq_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_p,
   input  logic             i_msb,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH:0]   o_p_next,
   output logic             o_q_bit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;
   // The restored remainder is always below the divisor, so its top bit is 0.
   logic             w_unused_ptop;

   assign w_unused_ptop = i_p[WIDTH];
   assign w_shift       = {i_p[WIDTH-1:0], i_msb};
   assign w_diff        = {1'b0, w_shift} - {2'b00, i_divisor};
   assign o_q_bit       = ~w_diff[WIDTH+1];
   assign o_p_next      = o_q_bit ? w_diff[WIDTH:0] : w_shift;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on
// both sides. Signed division is built only when DIV_SIGNED_EN is defined.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// CALC   | one restoring step per cycle, counter WIDTH-1 down to 0
// FIX    | signed sign correction of quotient and remainder
// DONE   | result held on outputs until out_ready
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_div_zero,
   output logic             out_overflow
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_p;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_q;
   logic             r_valid;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_dz;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_p_next;
   logic             w_q_bit;
   logic [WIDTH-1:0] w_q_next;

`ifdef DIV_SIGNED_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic w_a_neg;
   logic w_b_neg;
   logic w_ovf;
   logic r_sgn_op;
   logic r_neg_q;
   logic r_neg_r;
   logic r_ovf_pend;
   logic r_ovf;

   assign w_a_neg      = in_signed & in_dividend[WIDTH-1];
   assign w_b_neg      = in_signed & in_divisor[WIDTH-1];
   assign w_a_mag      = w_a_neg ? (~in_dividend + 1'b1) : in_dividend;
   assign w_b_mag      = w_b_neg ? (~in_divisor + 1'b1) : in_divisor;
   assign w_ovf        = in_signed && (in_dividend == MOST_NEG) && (&in_divisor);
   assign out_overflow = r_ovf;
`else
   logic w_unused_signed;

   assign w_unused_signed = in_signed;
   assign w_a_mag         = in_dividend;
   assign w_b_mag         = in_divisor;
   assign out_overflow    = 1'b0;
`endif

   div_seq_step #(.WIDTH(WIDTH)) u_step (
      .i_p       (r_p),
      .i_msb     (r_dvd[WIDTH-1]),
      .i_divisor (r_dvs),
      .o_p_next  (w_p_next),
      .o_q_bit   (w_q_bit)
   );

   assign w_q_next = {r_q[WIDTH-2:0], w_q_bit};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_p     <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dz    <= 1'b0;
`ifdef DIV_SIGNED_EN
         r_sgn_op   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_ovf_pend <= 1'b0;
         r_ovf      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (in_divisor == '0) begin
                     r_quo   <= {WIDTH{DIVZ_Q_FILL}};
                     r_rem   <= in_dividend;
                     r_dz    <= 1'b1;
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
`ifdef DIV_SIGNED_EN
                     r_ovf   <= 1'b0;
`endif
                  end else begin
                     r_dvd   <= w_a_mag;
                     r_dvs   <= w_b_mag;
                     r_p     <= '0;
                     r_q     <= '0;
                     r_cnt   <= CNT_LAST;
                     r_state <= S_CALC;
`ifdef DIV_SIGNED_EN
                     r_sgn_op   <= in_signed;
                     r_neg_q    <= w_a_neg ^ w_b_neg;
                     r_neg_r    <= w_a_neg;
                     r_ovf_pend <= w_ovf;
`endif
                  end
               end
            end
            S_CALC: begin
               r_p   <= w_p_next;
               r_q   <= w_q_next;
               r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
                  if (r_sgn_op) begin
                     r_state <= S_FIX;
                  end else begin
                     r_quo   <= w_q_next;
                     r_rem   <= w_p_next[WIDTH-1:0];
                     r_dz    <= 1'b0;
                     r_ovf   <= 1'b0;
                     r_valid <= 1'b1;
                     r_state <= S_DONE;
                  end
`else
                  r_quo   <= w_q_next;
                  r_rem   <= w_p_next[WIDTH-1:0];
                  r_dz    <= 1'b0;
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
`endif
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
`ifdef DIV_SIGNED_EN
            S_FIX: begin
               r_quo   <= r_neg_q ? (~r_q + 1'b1) : r_q;
               r_rem   <= r_neg_r ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0];
               r_dz    <= 1'b0;
               r_ovf   <= r_ovf_pend;
               r_valid <= 1'b1;
               r_state <= S_DONE;
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready      = (r_state == S_IDLE) && !rst;
   assign out_valid     = r_valid;
   assign out_quotient  = r_quo;
   assign out_remainder = r_rem;
   assign out_div_zero  = r_dz;

endmodule
